apb_rambus_bridge: RTL and testbench

Registered bridge between the MSS fabric APB slave port (AMBA_SLAVE_0, 14-bit address, 32-bit data) and the RamBus register interface of the DM main-ports core. It converts each APB transfer into one RamBus cycle (chip-select, write/read, latch strobe), then waits for RamBusAck. It returns read data and PREADY to the MSS, and flags PSLVERR when the core does not acknowledge within a bounded time. It sits directly upstream of the DM main-ports core and replaces the direct APB-to-RamBus wiring.

---
 rtl/apb_rambus_bridge.sv | 140 ++++++++++++++
 tb/tb_apb_rambus_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rambus_bridge.sv
// APB slave to RamBus register-interface bridge: one registered RamBus cycle per APB
// transfer, with a bounded wait for RamBusAck and PSLVERR on timeout.
module apb_rambus_bridge #(
  parameter int                ADDR_W         = 14,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [ADDR_W-1:0] RamBusAddress,
  output logic [DATA_W-1:0] RamBusDataIn,
  output logic              RamBusnCs,
  output logic              RamBusWrnRd,
  output logic              RamBusLatch,
  input  logic [DATA_W-1:0] RamBusDataOut,
  input  logic              RamBusAck,
  output logic [7:0]        timeout_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateType;

  // Index of the last wait cycle; a missing ack on that cycle is a timeout.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  stateType          stateReg, stateNext;
  logic [15:0]       waitCntReg, waitCntNext;
  logic [DATA_W-1:0] prdataNext;
  logic              preadyNext, pslverrNext;
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] dataInNext;
  logic              nCsNext, wrNRdNext, latchNext;
  logic [7:0]        toCountNext;

  assign busy = (stateReg != IDLE);

  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    prdataNext  = PRDATA;
    preadyNext  = 1'b0;
    pslverrNext = 1'b0;
    addrNext    = RamBusAddress;
    dataInNext  = RamBusDataIn;
    wrNRdNext   = RamBusWrnRd;
    nCsNext     = RamBusnCs;
    latchNext   = 1'b0;
    toCountNext = timeout_count;

    case (stateReg)
      IDLE: begin
        nCsNext = 1'b1;
        // Only a genuine setup phase starts a transfer; a bare access phase is ignored.
        if (PSEL && !PENABLE) begin
          addrNext   = PADDR;
          dataInNext = PWDATA;
          wrNRdNext  = PWRITE;
          nCsNext    = 1'b0;
          latchNext  = 1'b1;
          stateNext  = ISSUE;
        end
      end
      ISSUE: begin
        waitCntNext = '0;
        if (!PSEL) begin
          nCsNext   = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          nCsNext   = 1'b1;
          stateNext = IDLE;
        end else if (RamBusAck) begin
          // Ack is checked before the timeout so a late-but-valid ack is never an error.
          nCsNext    = 1'b1;
          preadyNext = 1'b1;
          stateNext  = RESP;
          if (!RamBusWrnRd) prdataNext = RamBusDataOut;
        end else if (waitCntReg >= WAIT_LAST) begin
          nCsNext     = 1'b1;
          preadyNext  = 1'b1;
          pslverrNext = 1'b1;
          stateNext   = RESP;
          if (!RamBusWrnRd) prdataNext = ERR_RDATA;
          if (timeout_count != 8'hFF) toCountNext = timeout_count + 8'd1;
        end else begin
          waitCntNext = waitCntReg + 16'd1;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        nCsNext   = 1'b1;
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg      <= IDLE;
      waitCntReg    <= '0;
      PRDATA        <= '0;
      PREADY        <= 1'b0;
      PSLVERR       <= 1'b0;
      RamBusAddress <= '0;
      RamBusDataIn  <= '0;
      RamBusnCs     <= 1'b1;
      RamBusWrnRd   <= 1'b0;
      RamBusLatch   <= 1'b0;
      timeout_count <= '0;
    end else begin
      stateReg      <= stateNext;
      waitCntReg    <= waitCntNext;
      PRDATA        <= prdataNext;
      PREADY        <= preadyNext;
      PSLVERR       <= pslverrNext;
      RamBusAddress <= addrNext;
      RamBusDataIn  <= dataInNext;
      RamBusnCs     <= nCsNext;
      RamBusWrnRd   <= wrNRdNext;
      RamBusLatch   <= latchNext;
      timeout_count <= toCountNext;
    end
  end

endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Directed scoreboard bench for apb_rambus_bridge with a short timeout so the
// timeout and saturation paths run quickly.
module tb_apb_rambus_bridge;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [13:0] RamBusAddress;
  logic [31:0] RamBusDataIn;
  logic        RamBusnCs;
  logic        RamBusWrnRd;
  logic        RamBusLatch;
  logic [31:0] RamBusDataOut = '0;
  logic        RamBusAck = 1'b0;
  logic [7:0]  timeout_count;
  logic        busy;

  always #5 clk = ~clk;

  apb_rambus_bridge #(
    .ADDR_W(14), .DATA_W(32), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .rst(rst),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .RamBusAddress(RamBusAddress), .RamBusDataIn(RamBusDataIn), .RamBusnCs(RamBusnCs),
    .RamBusWrnRd(RamBusWrnRd), .RamBusLatch(RamBusLatch),
    .RamBusDataOut(RamBusDataOut), .RamBusAck(RamBusAck),
    .timeout_count(timeout_count), .busy(busy)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } respT;

  respT        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdlPrdata = '0;
  int          mdlTo = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are registered, so sampling 1 time unit after the edge is stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetChecks(input string tag);
    chk({tag, "_prdata"}, PRDATA, 32'd0);
    chk({tag, "_pready"}, 32'(PREADY), 32'd0);
    chk({tag, "_pslverr"}, 32'(PSLVERR), 32'd0);
    chk({tag, "_addr"}, 32'(RamBusAddress), 32'd0);
    chk({tag, "_datain"}, RamBusDataIn, 32'd0);
    chk({tag, "_ncs"}, 32'(RamBusnCs), 32'd1);
    chk({tag, "_wrnrd"}, 32'(RamBusWrnRd), 32'd0);
    chk({tag, "_latch"}, 32'(RamBusLatch), 32'd0);
    chk({tag, "_tocount"}, 32'(timeout_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Full APB transfer starting in the current cycle (T0). ackAt is the cycle index
  // in which RamBusAck is pulsed; -1 means the core never answers.
  task automatic xfer(input logic wr, input logic [13:0] addr, input logic [31:0] wdata,
                      input int ackAt, input logic [31:0] coreData);
    bit   timedOut;
    int   respCycle;
    bit   done;
    respT exp;
    respT got;
    timedOut  = (ackAt < 2) || (ackAt > TO + 1);
    respCycle = timedOut ? TO + 2 : ackAt + 1;
    if (!wr) mdlPrdata = timedOut ? ERR : coreData;
    exp.rdata = mdlPrdata;
    exp.err   = timedOut;
    sbq.push_back(exp);
    if (timedOut && mdlTo < 255) mdlTo++;

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; RamBusAck = 1'b0;
    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      tick();
      PENABLE       = 1'b1;
      RamBusAck     = (k == ackAt);
      RamBusDataOut = (k == ackAt) ? coreData : $urandom();
      if (PREADY) begin
        chk("resp_cycle", 32'(k), 32'(respCycle));
        chk("sb_depth", 32'(sbq.size()), 32'd1);
        if (sbq.size() > 0) begin
          got = sbq.pop_front();
          chk("prdata", PRDATA, got.rdata);
          chk("pslverr", 32'(PSLVERR), 32'(got.err));
        end
        chk("ncs_resp", 32'(RamBusnCs), 32'd1);
        done = 1'b1;
      end else begin
        chk("latch", 32'(RamBusLatch), 32'(k == 1));
        chk("ncs_active", 32'(RamBusnCs), 32'd0);
        chk("addr", 32'(RamBusAddress), 32'(addr));
        chk("datain", RamBusDataIn, wdata);
        chk("wrnrd", 32'(RamBusWrnRd), 32'(wr));
        chk("busy_active", 32'(busy), 32'd1);
      end
    end
    if (!done) begin
      chk("pready_never", 32'(PREADY), 32'd1);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; RamBusAck = 1'b0;
    chk("pready_clear", 32'(PREADY), 32'd0);
    chk("pslverr_clear", 32'(PSLVERR), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("ncs_idle", 32'(RamBusnCs), 32'd1);
    chk("tocount", 32'(timeout_count), 32'(mdlTo));
    $display("xfer %s addr=%h wdata=%h ackAt=%0d prdata=%h tocount=%0d",
             wr ? "WR" : "RD", addr, wdata, ackAt, PRDATA, timeout_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    resetChecks("rst_init");
    rst = 1'b0;
    tick();

    // Basic write and read with the plan's ack timing, back to back.
    xfer(1'b1, 14'h0010, 32'h12345678, 3, 32'h0);
    xfer(1'b0, 14'h3FFC, 32'h0, 2, 32'hA5A5F00D);
    // Ack landing on the final wait cycle must win over the timeout.
    xfer(1'b0, 14'h0020, 32'h0, TO + 1, 32'hCAFE0001);
    // First timeout: error response and count 0 -> 1.
    xfer(1'b0, 14'h0024, 32'h0, -1, 32'h0);
    // A write that times out leaves PRDATA alone.
    xfer(1'b1, 14'h0028, 32'h55AA55AA, -1, 32'h0);

    // Bare access phase in IDLE is ignored.
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 14'h0030;
    tick();
    chk("ignore_busy", 32'(busy), 32'd0);
    chk("ignore_ncs", 32'(RamBusnCs), 32'd1);
    tick();
    chk("ignore_pready", 32'(PREADY), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();

    // Abort: PSEL drops during WAIT.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 14'h0100; RamBusAck = 1'b0;
    tick();
    PENABLE = 1'b1;
    chk("abort_latch", 32'(RamBusLatch), 32'd1);
    tick();
    chk("abort_ncs_wait", 32'(RamBusnCs), 32'd0);
    chk("abort_pready_wait", 32'(PREADY), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    chk("abort_ncs", 32'(RamBusnCs), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pready", 32'(PREADY), 32'd0);
    tick();
    chk("abort_pready2", 32'(PREADY), 32'd0);
    chk("abort_tocount", 32'(timeout_count), 32'(mdlTo));
    xfer(1'b0, 14'h0104, 32'h0, 4, 32'h0BADF00D);

    // A handful of randomised transfers, some of them timing out.
    for (int i = 0; i < 10; i++) begin
      xfer(1'($urandom_range(0, 1)), 14'($urandom()), $urandom(),
           int'($urandom_range(2, 12)), $urandom());
    end

    // Drive the timeout counter into saturation.
    for (int i = 0; i < 300; i++) xfer(1'b0, 14'h0200, 32'h0, -1, 32'h0);
    chk("tocount_sat", 32'(timeout_count), 32'd255);

    // Reset pulsed mid-cycle while in WAIT.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 14'h0300; PWDATA = 32'h0F0F0F0F;
    tick();
    PENABLE = 1'b1;
    tick();
    chk("rstmid_busy_wait", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    resetChecks("rst_mid");
    mdlPrdata = '0;
    mdlTo     = 0;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("rstmid_pready", 32'(PREADY), 32'd0);
    rst = 1'b0;
    tick();
    xfer(1'b1, 14'h0304, 32'h87654321, 2, 32'h0);
    xfer(1'b0, 14'h0308, 32'h0, 5, 32'h13579BDF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
